// File: rtl/cdic_clock_pkg.sv
// cdic_clock_pkg
//   Shared constants and types for the CDIC fractional tick generator.
//   - kTickNumCh / kTickAccW : default channel count and accumulator width
//   - tick_ratio_t           : num/den pair describing one tick rate
//   - kTickDefaults          : reset ratios for the 75 Hz sector, 37.8 kHz,
//                              44.1 kHz and 45 kHz MPEG streams (30 MHz clock)
//   - tick_default()         : reset ratio for any channel index; channels
//                              beyond the named ones reuse the sector rate
package cdic_clock_pkg;

    localparam int kTickNumCh = 4;
    localparam int kTickAccW  = 20;

    localparam int kTickSector = 0;
    localparam int kTickS37    = 1;
    localparam int kTickS44    = 2;
    localparam int kTickMpeg45 = 3;

    typedef struct packed {
        logic [kTickAccW-1:0] num;
        logic [kTickAccW-1:0] den;
    } tick_ratio_t;

    localparam tick_ratio_t kTickDefaults [4] = '{
        '{num: 20'd1,   den: 20'd400000},  // 75 Hz
        '{num: 20'd63,  den: 20'd50000},   // 37.8 kHz
        '{num: 20'd147, den: 20'd100000},  // 44.1 kHz
        '{num: 20'd3,   den: 20'd2000}     // 45 kHz
    };

    function automatic tick_ratio_t tick_default(input int ch);
        if (ch >= 0 && ch < 4) return kTickDefaults[ch];
        return kTickDefaults[kTickSector];
    endfunction

endpackage

// File: rtl/cdic_frac_divider.sv
// cdic_frac_divider
//   One fractional tick channel: acc += num each enabled cycle, and whenever
//   the sum reaches den, den is subtracted and a registered one-cycle tick
//   is emitted. Long-term rate is exactly clk * num / den.
//   Ports:
//     clk_i, reset_i     clock, synchronous active-high reset
//     en_i               run enable; acc holds while low
//     clr_i              clear acc and suppress tick (resync)
//     load_i             accept new num/den; also clears acc, suppresses tick
//     lock_i             force acc to 0 after this cycle's compare
//     cfg_num_i/den_i    ratio to load
//     hit_o              combinational: tick will be registered this edge
//     tick_o             registered tick pulse
module cdic_frac_divider #(
    parameter int              ACC_W   = 20,
    parameter logic [ACC_W-1:0] NUM_RST = '0,
    parameter logic [ACC_W-1:0] DEN_RST = '1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             lock_i,
    input  logic [ACC_W-1:0] cfg_num_i,
    input  logic [ACC_W-1:0] cfg_den_i,
    output logic             hit_o,
    output logic             tick_o
);

    logic [ACC_W-1:0] num_q, num_d;
    logic [ACC_W-1:0] den_q, den_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             tick_q, tick_d;

    // One extra bit so acc + num can never wrap before the compare.
    logic [ACC_W:0] sum;
    logic [ACC_W:0] diff;
    logic           ge;

    assign sum  = {1'b0, acc_q} + {1'b0, num_q};
    assign diff = sum - {1'b0, den_q};
    assign ge   = (sum >= {1'b0, den_q});

    assign hit_o = en_i & ~clr_i & ~load_i & ge;

    always_comb begin
        num_d  = num_q;
        den_d  = den_q;
        acc_d  = acc_q;
        tick_d = 1'b0;
        if (clr_i || load_i) begin
            acc_d = '0;
            if (load_i) begin
                num_d = cfg_num_i;
                den_d = cfg_den_i;
            end
        end else if (en_i) begin
            if (ge) begin
                acc_d  = diff[ACC_W-1:0];
                tick_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
            // Phase lock re-zeroes acc but keeps this cycle's own tick.
            if (lock_i) acc_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            num_q  <= NUM_RST;
            den_q  <= DEN_RST;
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            num_q  <= num_d;
            den_q  <= den_d;
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/cdic_frac_tick_gen.sv
// cdic_frac_tick_gen
//   Multi-channel fractional tick generator. Each channel emits one-cycle
//   ticks at an exact average rate of clk * num / den, so all CDIC audio,
//   sector and MPEG rates come from the single system clock.
//   Ports:
//     clk_i, reset_i     clock, synchronous active-high reset
//     ch_en_i            per-channel run enable
//     resync_i           clear all accumulators, suppress all ticks
//     lock_mask_i        channels re-phased on every channel-0 tick (bit 0 unused)
//     cfg_we_i           ratio write strobe for channel cfg_ch_i
//     cfg_num_i/den_i    new ratio; accepted only if 0 < num < den
//     cfg_err_o          registered pulse: previous write rejected
//     tick_o             registered tick pulses
//   Build option: CDIC_TICK_LOCK_EN enables phase locking to channel 0;
//   without it lock_mask_i is ignored.
module cdic_frac_tick_gen
    import cdic_clock_pkg::*;
#(
    parameter int NUM_CH = kTickNumCh,
    parameter int ACC_W  = kTickAccW,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NUM_CH-1:0] ch_en_i,
    input  logic              resync_i,
    input  logic [NUM_CH-1:0] lock_mask_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [ACC_W-1:0]  cfg_num_i,
    input  logic [ACC_W-1:0]  cfg_den_i,
    output logic              cfg_err_o,
    output logic [NUM_CH-1:0] tick_o
);

    logic              cfg_valid;
    logic              cfg_err_q, cfg_err_d;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] lock;
    logic [NUM_CH-1:0] hit;

    assign cfg_valid = (cfg_num_i != '0) && (cfg_num_i < cfg_den_i)
                     && (int'(cfg_ch_i) < NUM_CH);

    // A rejected write is reported even during resync; a valid write that
    // collides with resync is dropped, since resync outranks configuration.
    assign cfg_err_d = cfg_we_i & ~cfg_valid;

    always_ff @(posedge clk_i) begin
        if (reset_i) cfg_err_q <= 1'b0;
        else         cfg_err_q <= cfg_err_d;
    end

    assign cfg_err_o = cfg_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam tick_ratio_t kDef = tick_default(i);

        assign load[i] = cfg_we_i & cfg_valid & ~resync_i
                       & (cfg_ch_i == CH_W'(i));

`ifdef CDIC_TICK_LOCK_EN
        // Channel 0 is the phase reference; its hit re-zeroes locked peers
        // on the same edge so their next tick lands ceil(den/num) later.
        if (i == 0) begin : g_ref
            assign lock[i] = 1'b0;
        end else begin : g_lock
            assign lock[i] = lock_mask_i[i] & hit[0];
        end
`else
        assign lock[i] = 1'b0;
`endif

        cdic_frac_divider #(
            .ACC_W   (ACC_W),
            .NUM_RST (ACC_W'(kDef.num)),
            .DEN_RST (ACC_W'(kDef.den))
        ) u_div (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .en_i      (ch_en_i[i]),
            .clr_i     (resync_i),
            .load_i    (load[i]),
            .lock_i    (lock[i]),
            .cfg_num_i (cfg_num_i),
            .cfg_den_i (cfg_den_i),
            .hit_o     (hit[i]),
            .tick_o    (tick_o[i])
        );
    end

endmodule

// File: tb/tb_cdic_frac_tick_gen.sv
// Self-checking bench for cdic_frac_tick_gen (4 channels, 20-bit acc).
// Reference model tracks, per channel, the number of enabled cycles n since
// the last clear; a tick is due whenever floor(n*num/den) increments.
module tb_cdic_frac_tick_gen;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        reset, resync, cfg_we, cfg_err;
    logic [3:0]  ch_en, lock_mask, tick;
    logic [1:0]  cfg_ch;
    logic [19:0] cfg_num, cfg_den;

    always #5 clk = ~clk;

    cdic_frac_tick_gen #(.NUM_CH(NCH), .ACC_W(20)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .ch_en_i     (ch_en),
        .resync_i    (resync),
        .lock_mask_i (lock_mask),
        .cfg_we_i    (cfg_we),
        .cfg_ch_i    (cfg_ch),
        .cfg_num_i   (cfg_num),
        .cfg_den_i   (cfg_den),
        .cfg_err_o   (cfg_err),
        .tick_o      (tick)
    );

    int n_chk  = 0;
    int n_fail = 0;

    longint mn[NCH], mnum[NCH], mden[NCH];

    typedef struct {
        int ch;
        int num;
        int den;
        bit err;
        int first;   // expected edges to first tick after an accepted write
    } cfg_vec_t;

    cfg_vec_t tbl[8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit crossed(input longint n, input longint num, input longint den);
        return ((n * num) / den) != (((n - 1) * num) / den);
    endfunction

    // Expected outputs right after the coming edge, from the current inputs.
    task automatic model_edge(output logic [3:0] et, output logic ee);
        bit valid;
        bit ld[NCH];
        et = '0;
        ee = 1'b0;
        if (reset) begin
            mnum = '{1, 63, 147, 3};
            mden = '{400000, 50000, 100000, 2000};
            mn   = '{0, 0, 0, 0};
            return;
        end
        valid = (cfg_num != 0) && (cfg_num < cfg_den);
        ee = cfg_we && !valid;
        if (resync) begin
            for (int i = 0; i < NCH; i++) mn[i] = 0;
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            ld[i] = cfg_we && valid && (cfg_ch == i);
            if (ld[i]) begin
                mnum[i] = cfg_num;
                mden[i] = cfg_den;
                mn[i]   = 0;
            end else if (ch_en[i]) begin
                mn[i]++;
                et[i] = crossed(mn[i], mnum[i], mden[i]);
            end
        end
`ifdef CDIC_TICK_LOCK_EN
        if (et[0]) begin
            for (int i = 1; i < NCH; i++)
                if (lock_mask[i] && ch_en[i] && !ld[i]) mn[i] = 0;
        end
`endif
    endtask

    task automatic step();
        logic [3:0] et;
        logic       ee;
        model_edge(et, ee);
        @(posedge clk);
        #1;
        chk("tick_model", tick, et);
        chk("cfg_err_model", cfg_err, ee);
    endtask

    task automatic cfg_write(input int ch, input int num, input int den);
        cfg_ch  = 2'(ch);
        cfg_num = 20'(num);
        cfg_den = 20'(den);
        cfg_we  = 1'b1;
        step();
        cfg_we  = 1'b0;
    endtask

    // Edges until tick[ch] rises; -1 when the limit expires.
    task automatic wait_tick(input int ch, input int limit, output int k);
        k = -1;
        for (int j = 1; j <= limit; j++) begin
            step();
            if (tick[ch]) begin
                k = j;
                return;
            end
        end
    endtask

    initial begin
        int cnt[NCH];
        int first[NCH];
        int exp_first[NCH];
        int last1, k, k2, c3, o1, o2;

        reset = 1'b1; resync = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_num = '0; cfg_den = '0; ch_en = '0; lock_mask = '0;
        step();
        step();
        chk("reset_tick", tick, 0);
        chk("reset_cfg_err", cfg_err, 0);
        reset = 1'b0;

        // Free run from reset: one full 50000-cycle window of ch1.
        ch_en = 4'hF;
        cnt   = '{0, 0, 0, 0};
        last1 = -1;
        for (int e = 1; e <= 50000; e++) begin
            step();
            for (int i = 0; i < NCH; i++) if (tick[i]) cnt[i]++;
            if (tick[1]) begin
                if (last1 >= 0)
                    chk("ch1_spacing_793_794", ((e - last1) == 793) || ((e - last1) == 794), 1);
                last1 = e;
            end
        end
        chk("count_ch0", cnt[0], 0);
        chk("count_ch1", cnt[1], 63);
        chk("count_ch2", cnt[2], 73);
        chk("count_ch3", cnt[3], 75);

        // Config writes: rejects first, then accepted ratios.
        tbl[0] = '{ch: 3, num: 0, den: 10,   err: 1'b1, first: 0};
        tbl[1] = '{ch: 3, num: 5, den: 5,    err: 1'b1, first: 0};
        tbl[2] = '{ch: 3, num: 7, den: 3,    err: 1'b1, first: 0};
        tbl[3] = '{ch: 3, num: 1, den: 10,   err: 1'b0, first: 10};
        tbl[4] = '{ch: 2, num: 3, den: 10,   err: 1'b0, first: 4};
        tbl[5] = '{ch: 1, num: 2, den: 7,    err: 1'b0, first: 4};
        tbl[6] = '{ch: 0, num: 1, den: 4000, err: 1'b0, first: 4000};
        tbl[7] = '{ch: 3, num: 1, den: 10,   err: 1'b0, first: 10};
        for (int v = 0; v < 8; v++) begin
            cfg_write(tbl[v].ch, tbl[v].num, tbl[v].den);
            chk("cfg_err_tbl", cfg_err, tbl[v].err);
            if (!tbl[v].err) begin
                wait_tick(tbl[v].ch, tbl[v].first + 50, k);
                chk("cfg_first_tick", k, tbl[v].first);
            end
            if (v == 2) begin
                // ch3 must still run at 3/2000 after the rejected writes.
                wait_tick(3, 2100, k);
                wait_tick(3, 700, k2);
                chk("ch3_kept_ratio", (k2 == 666) || (k2 == 667), 1);
            end
        end

        // Resync mid-period.
        repeat (123) step();
        resync = 1'b1;
        step();
        chk("resync_no_tick", tick, 0);
        resync = 1'b0;
        first     = '{-1, -1, -1, -1};
        exp_first = '{4000, 4, 4, 10};
        for (int e = 1; e <= 4100; e++) begin
            step();
            for (int i = 0; i < NCH; i++)
                if (tick[i] && first[i] < 0) first[i] = e;
        end
        for (int i = 0; i < NCH; i++) chk("resync_first_tick", first[i], exp_first[i]);

        // Hold ch3 for 500 cycles at phase 3 of 10.
        wait_tick(3, 20, k);
        repeat (3) step();
        ch_en = 4'b0111;
        c3 = 0;
        repeat (500) begin
            step();
            if (tick[3]) c3++;
        end
        chk("ch3_disabled_ticks", c3, 0);
        ch_en = 4'hF;
        wait_tick(3, 20, k);
        chk("ch3_resume_phase", k, 7);

        // Phase lock of ch1 to ch0 after a skewing write.
        lock_mask = 4'b0010;
        repeat (1000) step();
        cfg_write(1, 63, 50000);
        chk("lock_cfg_ok", cfg_err, 0);
        wait_tick(0, 4100, k);
        chk("lock_ch0_seen", k > 0, 1);
        o1 = -1;
        o2 = -1;
        for (int e = 1; e <= 1700; e++) begin
            step();
            if (tick[1]) begin
                if (o1 < 0) o1 = e;
                else if (o2 < 0) o2 = e;
            end
        end
`ifdef CDIC_TICK_LOCK_EN
        chk("lock_offset1", o1, 794);
        chk("lock_offset2", o2, 1588);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NCH; i++) ch_en[i] = ($urandom_range(0, 99) < 85);
            resync  = ($urandom_range(0, 299) == 0);
            cfg_we  = !resync && ($urandom_range(0, 39) == 0);
            cfg_ch  = 2'($urandom_range(0, 3));
            cfg_num = 20'($urandom_range(0, 12));
            cfg_den = 20'($urandom_range(1, 40));
            if (c % 500 == 0) lock_mask = 4'($urandom);
            step();
        end
        cfg_we = 1'b0;
        resync = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
